// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction and status inputs, strobes, selects and debug outputs.
interface multicycle_control_if;
  logic [5:0]  opcode;
  logic        zero_flag;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  logic        illegal_op;
  logic        instr_retired;
  logic [31:0] instr_count;

  modport master (
    input  opcode, zero_flag, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, state, illegal_op, instr_retired, instr_count
  );

  modport slave (
    output opcode, zero_flag, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, state, illegal_op, instr_retired, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller (lw/sw/R/addi/beq/bne/j); MULTICYCLE_INSTR_COUNT_EN adds a retired-instruction counter.
// Outputs decode from state in the same cycle; FETCH, MEM_READ and MEM_WRITE stall indefinitely until mem_ready.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic       pc_write_c;
  logic       ir_write_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       mem_to_reg_c;
  logic       reg_dst_c;
  logic       reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic [1:0] pc_src_c;
  logic       illegal_c;
  logic       retired_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = 2'd0;
    pc_src_c     = 2'd0;
    illegal_c    = 1'b0;
    retired_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'd1;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        alu_src_b_c = 2'd3;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
        else                          state_d = S_FETCH;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retired_c    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        retired_c   = bus.mem_ready;
        state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'd2;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retired_c   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'd1;
        pc_src_c    = 2'd1;
        pc_write_c  = ((bus.opcode == OP_BEQ) &&  bus.zero_flag) ||
                      ((bus.opcode == OP_BNE) && !bus.zero_flag);
        retired_c   = 1'b1;
      end
      S_JUMP: begin
        pc_src_c   = 2'd2;
        pc_write_c = 1'b1;
        retired_c  = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        retired_c   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural side effects are suppressed while reset is held, even mid-instruction.
  assign bus.pc_write      = pc_write_c  & ~rst;
  assign bus.ir_write      = ir_write_c  & ~rst;
  assign bus.reg_write     = reg_write_c & ~rst;
  assign bus.mem_write     = mem_write_c & ~rst;
  assign bus.illegal_op    = illegal_c   & ~rst;
  assign bus.instr_retired = retired_c   & ~rst;

  assign bus.i_or_d     = i_or_d_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.state      = state_q;

`ifdef MULTICYCLE_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)            count_q <= 32'd0;
    else if (retired_c) count_q <= count_q + 32'd1;
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = 32'd0;
`endif

endmodule
